// File: rtl/inst_sequencer.sv
// Fetch/execute sequencer: fetches one instruction byte, then runs one (inst[7]=0) or two (inst[7]=1) exec phases.
// Optional single-step debug gating of fetch requests is enabled by defining SEQ_STEP_EN.
module inst_sequencer (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SEQ_STEP_EN
    input  logic        step,
`endif
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic        J,
    input  logic        LJ,
    input  logic [15:0] target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic [15:0] pc,
    output logic [7:0]  inst,
    output logic        cycle,
    output logic        inst_valid
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC0 = 2'd1,
        EXEC1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic                mem_req_q, mem_req_d;
    logic                inst_valid_q, inst_valid_d;
    logic                cycle_q, cycle_d;
    logic                exit_c;
    logic                go_c;
`ifdef SEQ_STEP_EN
    logic                step_pend_q, step_pend_d;
`endif

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        mem_req_d    = mem_req_q;
        inst_valid_d = inst_valid_q;
        cycle_d      = cycle_q;
        exit_c       = 1'b0;
`ifdef SEQ_STEP_EN
        go_c         = step | step_pend_q;
        step_pend_d  = step_pend_q;
`else
        go_c         = 1'b1;
`endif
        case (state_q)
            FETCH: begin
                if (mem_req_q && mem_ack) begin
                    inst_d       = mem_rdata;
                    pc_d         = pc_q + ADDR_W'(1);
                    state_d      = EXEC0;
                    mem_req_d    = 1'b0;
                    inst_valid_d = 1'b1;
                    cycle_d      = 1'b0;
                end else begin
                    mem_req_d = mem_req_q | go_c;
                end
            end
            EXEC0: begin
                if (inst_q[7]) begin
                    state_d = EXEC1;
                    cycle_d = 1'b1;
                end else begin
                    if (LJ) pc_d = target;
                    exit_c = 1'b1;
                end
            end
            EXEC1: begin
                if (J) pc_d = target;
                exit_c = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Leaving execution: request the next fetch only when allowed to
        if (exit_c) begin
            state_d      = FETCH;
            inst_valid_d = 1'b0;
            cycle_d      = 1'b0;
            mem_req_d    = go_c;
        end

`ifdef SEQ_STEP_EN
        // One pending step captured during execution; consumed when a fetch is launched
        if (state_q == FETCH) begin
            if (!mem_req_q) step_pend_d = 1'b0;
        end else if (exit_c && go_c) begin
            step_pend_d = 1'b0;
        end else begin
            step_pend_d = step_pend_q | step;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= '0;
            inst_q       <= '0;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            cycle_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
            cycle_q      <= cycle_d;
        end
    end

`ifdef SEQ_STEP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) step_pend_q <= 1'b0;
        else        step_pend_q <= step_pend_d;
    end
`endif

    assign mem_req    = mem_req_q;
    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign cycle      = cycle_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed scoreboard bench for inst_sequencer; covers the SEQ_STEP_EN build when that macro is defined.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        J;
    logic        LJ;
    logic [15:0] target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] pc;
    logic [7:0]  inst;
    logic        cycle;
    logic        inst_valid;
`ifdef SEQ_STEP_EN
    logic        step;
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] model_pc;
    bit          auto_step = 1'b0;

    typedef struct {
        logic [7:0]  inst;
        logic [15:0] pc_after;
        logic [15:0] next_addr;
    } exp_t;
    exp_t exp_q[$];

    inst_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SEQ_STEP_EN
        .step       (step),
`endif
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .J          (J),
        .LJ         (LJ),
        .target     (target),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .pc         (pc),
        .inst       (inst),
        .cycle      (cycle),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic kick();
`ifdef SEQ_STEP_EN
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
`endif
    endtask

    // One instruction: fetch (with optional wait states), then exec phases with jump inputs
    task automatic do_instr(input logic [7:0] b, input int waits, input logic j0,
                            input logic j1, input logic lj, input logic [15:0] tgt,
                            input logic noisy);
        exp_t e;
        int   n;
        e.inst      = b;
        e.pc_after  = model_pc + 16'd1;
        if (b[7]) e.next_addr = j1 ? tgt : model_pc + 16'd1;
        else      e.next_addr = lj ? tgt : model_pc + 16'd1;
        exp_q.push_back(e);

        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", mem_req, 1'b1);
        check("fetch_addr", mem_addr, model_pc);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("wait_req", mem_req, 1'b1);
            check("wait_addr", mem_addr, model_pc);
        end
        mem_ack = 1'b1;
        mem_rdata = b;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 8'h00;

        e = exp_q.pop_front();
        check("exec0_inst", inst, e.inst);
        check("exec0_valid", inst_valid, 1'b1);
        check("exec0_cycle", cycle, 1'b0);
        check("exec0_pc", pc, e.pc_after);
        check("exec0_req", mem_req, 1'b0);
        J = j0;
        LJ = lj;
        target = tgt;
        if (noisy) begin
            mem_ack = 1'b1;
            mem_rdata = ~b;
        end
`ifdef SEQ_STEP_EN
        step = auto_step;
`endif
        @(negedge clk);
        J = 1'b0;
        LJ = 1'b0;
        mem_ack = 1'b0;
`ifdef SEQ_STEP_EN
        step = 1'b0;
`endif
        if (b[7]) begin
            check("exec1_inst", inst, e.inst);
            check("exec1_valid", inst_valid, 1'b1);
            check("exec1_cycle", cycle, 1'b1);
            J = j1;
            if (noisy) begin
                mem_ack = 1'b1;
                mem_rdata = ~b;
            end
            @(negedge clk);
            J = 1'b0;
            mem_ack = 1'b0;
        end
        check("back_valid", inst_valid, 1'b0);
        check("back_cycle", cycle, 1'b0);
        check("back_addr", mem_addr, e.next_addr);
        check("back_req", mem_req, STEP_MODE ? auto_step : 1'b1);
        model_pc = e.next_addr;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rdata = 8'h00;
        mem_ack = 1'b0;
        J = 1'b0;
        LJ = 1'b0;
        target = 16'h0000;
`ifdef SEQ_STEP_EN
        step = 1'b0;
`endif
        model_pc = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_req", mem_req, 1'b0);
        check("rst_pc", pc, 16'h0000);
        check("rst_inst", inst, 8'h00);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_cycle", cycle, 1'b0);

        rst_n = 1'b1;
`ifdef SEQ_STEP_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("nostep_req", mem_req, 1'b0);
        end
        kick();
        do_instr(8'h12, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("onestep_req", mem_req, 1'b0);
        end
        kick();
        auto_step = 1'b1;
`else
        @(negedge clk);
        check("post_rst_req", mem_req, 1'b1);
        check("post_rst_addr", mem_addr, 16'h0000);
        do_instr(8'h12, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
`endif
        do_instr(8'h85, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        do_instr(8'hE0, 1, 1'b0, 1'b1, 1'b0, 16'h4000, 1'b0);
        do_instr(8'hE0, 0, 1'b1, 1'b0, 1'b0, 16'h5555, 1'b0);
        do_instr(8'h10, 2, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1);
        do_instr(8'h10, 0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        do_instr(8'h22, 5, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        do_instr(8'h90, 0, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0);
        do_instr(8'h01, 0, 1'b1, 1'b0, 1'b0, 16'h3333, 1'b0);

        // Reset during EXEC1 with a jump pending, then with an ack in flight
        while (mem_req !== 1'b1 && model_pc != 16'hFFFF) begin
            @(negedge clk);
            model_pc = 16'hFFFF;
        end
        mem_ack = 1'b1;
        mem_rdata = 8'h80;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        check("pre_rst_cycle", cycle, 1'b1);
        J = 1'b1;
        target = 16'h7777;
        rst_n = 1'b0;
        @(negedge clk);
        J = 1'b0;
        check("abort_pc", pc, 16'h0000);
        check("abort_valid", inst_valid, 1'b0);
        check("abort_inst", inst, 8'h00);
        mem_ack = 1'b1;
        mem_rdata = 8'h55;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_ack_inst", inst, 8'h00);
        check("rst_ack_req", mem_req, 1'b0);
        rst_n = 1'b1;
`ifdef SEQ_STEP_EN
        step = 1'b1;
`endif
        @(negedge clk);
`ifdef SEQ_STEP_EN
        step = 1'b0;
`endif
        check("rerun_req", mem_req, 1'b1);
        check("rerun_addr", mem_addr, 16'h0000);
        model_pc = 16'h0000;
        do_instr(8'h12, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
